mixer_seq: RTL and testbench
============================

Name: mixer_seq

Overview:
- Parametrised, sequential successor to the synth's combinational voice mixer.
- On each sample strobe, snapshots NUM_VOICES unsigned voice samples and their enable bits, then accumulates enabled voices one per clock.
- Saturates the sum to OUT_W bits and presents it with a one-cycle valid pulse to the PWM/DAC stage.
- Sits between the per-voice oscillators and the audio output.

Parameters:
- NUM_VOICES, 13, number of voice channels (>=1).
- SAMPLE_W, 8, width of each unsigned voice sample.
- OUT_W, 8, width of the mixed output sample (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- sample_strobe  input  1  single-cycle request to start a new mix.
- voice_en  input  NUM_VOICES  per-voice enable (note active); bit i gates voice i.
- voice_sample  input  NUM_VOICES*SAMPLE_W  packed samples; voice i occupies bits [i*SAMPLE_W +: SAMPLE_W].
- mixed_sample  output  OUT_W  last completed mix, held until the next completion.
- mixed_valid  output  1  one-cycle pulse when mixed_sample updates.
- busy  output  1  high while a mix is in progress.
- overrun  output  1  sticky flag: strobe arrived while busy.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: mixed_sample=0, mixed_valid=0, busy=0, overrun=0, state=IDLE, accumulator=0, voice index=0.
- Reset mid-mix aborts the mix with no valid pulse.
- Accumulator width is ACC_W = SAMPLE_W + $clog2(NUM_VOICES+1). It never overflows internally.

State machine:
- IDLE:
  - On sample_strobe, snapshot voice_en and voice_sample into internal registers, clear the accumulator and index, set busy, go to ACCUM.
  - No strobe: stay in IDLE.
- ACCUM:
  - Each cycle, add snapshot sample[idx] if snapshot en[idx]=1, otherwise add 0. Increment idx.
  - After idx = NUM_VOICES-1 has been added, go to DONE.
  - Input changes during ACCUM have no effect because the snapshot is used.
- DONE (1 cycle):
  - mixed_sample <= (acc > 2^OUT_W-1) ? 2^OUT_W-1 : acc[OUT_W-1:0].
  - mixed_valid=1 this cycle only. busy drops at the end of this cycle. Return to IDLE.

Timing and boundary rules:
- Latency: strobe sampled in cycle 0 → mixed_valid asserted in cycle NUM_VOICES+1.
- Minimum strobe period is NUM_VOICES+2 cycles.
- Strobe while busy (ACCUM or DONE): ignored, overrun set to 1. overrun is cleared only by rst.
- Strobe in the cycle after DONE (state back in IDLE) is accepted normally.
- All voices disabled: result 0, valid still pulses.
- Saturation is exact at the boundary: sum = 2^OUT_W-1 passes unchanged; sum = 2^OUT_W clamps to 2^OUT_W-1.
- If OUT_W >= ACC_W, no clamping can occur and the result is zero-extended.
- NUM_VOICES=1: ACCUM lasts exactly 1 cycle.

Optional Feature:
- Macro: MIXER_NORM_EN.
- Defined:
  - ACCUM also counts enabled voices (cnt).
  - In DONE the sum is right-shifted by s = ceil(log2(cnt)), with s=0 for cnt of 0 or 1, before the saturation clamp.
  - Latency is unchanged.
  - Example: 3 voices of 200 give sum 600, s=2, result 150.
- Undefined: no count logic, no shift; saturation only, as above.

Test Plan:
- Reset, then idle for 20 cycles → mixed_sample=0, mixed_valid=0, busy=0, overrun=0.
- Defaults; voice_en=13'h0007, samples 10, 20, 30 on voices 0-2, others 255; strobe → valid exactly 14 cycles later, mixed_sample=60, busy high cycles 1-14.
- Defaults; all 13 voices enabled at 255 → sum 3315, mixed_sample=255. Second case: voices 0-1 at 128/127 → 255 (not clamped); 128/128 → 255 (clamped from 256).
- Strobe, change voice_sample and voice_en every cycle during ACCUM → result equals the snapshot sum. Second strobe at cycle 5 → ignored, overrun=1 and stays 1 until rst.
- Assert rst at cycle 7 of a mix → no valid pulse, all outputs 0 next cycle. New strobe after reset → correct result.
- With MIXER_NORM_EN, NUM_VOICES=4, SAMPLE_W=8, OUT_W=8: all 4 voices at 255 → 1020>>2 = 255. One voice at 77 → 77. None enabled → 0.

Source files
------------

// File: rtl/mixer_seq_if.sv
// Voice-mixer bus: oscillator-side inputs and DAC-side outputs of mixer_seq.
interface mixer_seq_if #(
  parameter int unsigned NUM_VOICES = 13,
  parameter int unsigned SAMPLE_W   = 8,
  parameter int unsigned OUT_W      = 8
);
  logic                           sample_strobe;
  logic [NUM_VOICES-1:0]          voice_en;
  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample;
  logic [OUT_W-1:0]               mixed_sample;
  logic                           mixed_valid;
  logic                           busy;
  logic                           overrun;

  modport master (
    output sample_strobe, voice_en, voice_sample,
    input  mixed_sample, mixed_valid, busy, overrun
  );

  modport slave (
    input  sample_strobe, voice_en, voice_sample,
    output mixed_sample, mixed_valid, busy, overrun
  );
endinterface

// File: rtl/mixer_seq.sv
// Sequential voice mixer: snapshots all voices on a strobe, sums enabled ones one per clock,
// saturates to OUT_W. Optional MIXER_NORM_EN scales the sum by the enabled-voice count.
module mixer_seq #(
  parameter int unsigned NUM_VOICES = 13,
  parameter int unsigned SAMPLE_W   = 8,
  parameter int unsigned OUT_W      = 8
) (
  input logic        clk,
  input logic        rst,
  mixer_seq_if.slave bus
);
  localparam int unsigned ACC_W = SAMPLE_W + $clog2(NUM_VOICES + 1);
  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned VEC_W = NUM_VOICES * SAMPLE_W;
  localparam int unsigned CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e                state_q, state_d;
  logic [NUM_VOICES-1:0] en_q, en_d;
  logic [VEC_W-1:0]      samp_q, samp_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [OUT_W-1:0]      mixed_sample_q, mixed_sample_d;
  logic                  mixed_valid_q, mixed_valid_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic [ACC_W-1:0]      sum_c;

`ifdef MIXER_NORM_EN
  localparam int unsigned CNT_W = $clog2(NUM_VOICES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Smallest s with 2^s >= n; 0 for n of 0 or 1.
  function automatic int unsigned ceil_log2(input logic [CNT_W-1:0] n);
    int unsigned s;
    s = 0;
    for (int unsigned k = 0; k <= CNT_W; k++) begin
      if (((CNT_W + 1)'(1) << k) < {1'b0, n}) s = s + 1;
    end
    ceil_log2 = s;
  endfunction
`endif

  function automatic logic [OUT_W-1:0] saturate(input logic [ACC_W-1:0] s);
    logic [CMP_W-1:0] ext;
    ext = CMP_W'(s);
    if (ext > CMP_W'({OUT_W{1'b1}})) saturate = '1;
    else saturate = OUT_W'(ext);
  endfunction

  // Snapshot is shifted down each ACCUM cycle so the current voice always sits at bit 0.
  always_comb begin
    state_d        = state_q;
    en_d           = en_q;
    samp_d         = samp_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    mixed_sample_d = mixed_sample_q;
    mixed_valid_d  = 1'b0;
    busy_d         = busy_q;
    overrun_d      = overrun_q;
    sum_c          = acc_q + (en_q[0] ? ACC_W'(samp_q[SAMPLE_W-1:0]) : '0);
`ifdef MIXER_NORM_EN
    cnt_d          = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.sample_strobe) begin
          en_d    = bus.voice_en;
          samp_d  = bus.voice_sample;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ACCUM;
`ifdef MIXER_NORM_EN
          cnt_d   = '0;
`endif
        end
      end
      ACCUM: begin
        if (bus.sample_strobe) overrun_d = 1'b1;
        acc_d  = sum_c;
        en_d   = en_q >> 1;
        samp_d = samp_q >> SAMPLE_W;
        idx_d  = idx_q + IDX_W'(1);
`ifdef MIXER_NORM_EN
        cnt_d  = cnt_q + CNT_W'(en_q[0]);
`endif
        // Result is registered on the final add so it is visible during DONE.
        if (idx_q == LAST_IDX) begin
          state_d       = DONE;
          mixed_valid_d = 1'b1;
`ifdef MIXER_NORM_EN
          mixed_sample_d = saturate(sum_c >> ceil_log2(cnt_d));
`else
          mixed_sample_d = saturate(sum_c);
`endif
        end
      end
      DONE: begin
        if (bus.sample_strobe) overrun_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      en_q           <= '0;
      samp_q         <= '0;
      acc_q          <= '0;
      idx_q          <= '0;
      mixed_sample_q <= '0;
      mixed_valid_q  <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef MIXER_NORM_EN
      cnt_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      en_q           <= en_d;
      samp_q         <= samp_d;
      acc_q          <= acc_d;
      idx_q          <= idx_d;
      mixed_sample_q <= mixed_sample_d;
      mixed_valid_q  <= mixed_valid_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
`ifdef MIXER_NORM_EN
      cnt_q          <= cnt_d;
`endif
    end
  end

  assign bus.mixed_sample = mixed_sample_q;
  assign bus.mixed_valid  = mixed_valid_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_mixer_seq.sv
// Self-checking bench for mixer_seq: directed and random mixes against a plain-arithmetic model.
module tb_mixer_seq;
`ifdef MIXER_NORM_EN
  localparam int unsigned NV = 4;
`else
  localparam int unsigned NV = 13;
`endif
  localparam int unsigned SW = 8;
  localparam int unsigned OW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  mixer_seq_if #(.NUM_VOICES(NV), .SAMPLE_W(SW), .OUT_W(OW)) bus ();
  mixer_seq #(.NUM_VOICES(NV), .SAMPLE_W(SW), .OUT_W(OW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: sum of enabled voices, optional count normalisation, clamp to OUT_W.
  function automatic logic [OW-1:0] ref_mix(input logic [NV-1:0] en, input logic [NV*SW-1:0] smp);
    longint sum = 0;
    int cnt = 0;
    int s = 0;
    for (int i = 0; i < int'(NV); i++) begin
      if (en[i]) begin
        sum += longint'(smp[i*SW +: SW]);
        cnt++;
      end
    end
`ifdef MIXER_NORM_EN
    while ((longint'(1) << s) < longint'(cnt)) s++;
    sum = sum >> s;
`endif
    if (sum > (longint'(1) << OW) - 1) sum = (longint'(1) << OW) - 1;
    return OW'(sum);
  endfunction

  function automatic logic [NV*SW-1:0] fill(input int unsigned v);
    logic [NV*SW-1:0] r;
    for (int i = 0; i < int'(NV); i++) r[i*SW +: SW] = SW'(v);
    return r;
  endfunction

  function automatic logic [NV*SW-1:0] rand_smp();
    logic [NV*SW-1:0] r;
    for (int i = 0; i < int'(NV); i++) r[i*SW +: SW] = SW'($urandom);
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the cycle after DONE.
  task automatic run_mix(input string tag, input logic [NV-1:0] en, input logic [NV*SW-1:0] smp,
                         input bit scramble, input int second_at);
    logic [OW-1:0] exp;
    exp = ref_mix(en, smp);
    bus.voice_en      = en;
    bus.voice_sample  = smp;
    bus.sample_strobe = 1'b1;
    @(negedge clk);
    bus.sample_strobe = 1'b0;
    for (int k = 1; k <= int'(NV) + 1; k++) begin
      chk({tag, "_busy"}, 64'(bus.busy), 64'(1));
      chk({tag, "_valid"}, 64'(bus.mixed_valid), 64'(k == int'(NV) + 1));
      if (k == int'(NV) + 1) chk({tag, "_sample"}, 64'(bus.mixed_sample), 64'(exp));
      if (scramble) begin
        bus.voice_en     = NV'($urandom);
        bus.voice_sample = rand_smp();
      end
      bus.sample_strobe = (k == second_at);
      @(negedge clk);
    end
    bus.sample_strobe = 1'b0;
    chk({tag, "_busy_end"}, 64'(bus.busy), 64'(0));
    chk({tag, "_valid_end"}, 64'(bus.mixed_valid), 64'(0));
    chk({tag, "_hold"}, 64'(bus.mixed_sample), 64'(exp));
  endtask

  initial begin
    logic [NV*SW-1:0] smp;
    logic [OW-1:0] exp;
    bus.sample_strobe = 1'b0;
    bus.voice_en      = '0;
    bus.voice_sample  = '0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("idle_valid", 64'(bus.mixed_valid), 64'(0));
    end
    chk("rst_sample", 64'(bus.mixed_sample), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_overrun", 64'(bus.overrun), 64'(0));

    smp = fill(255);
    smp[0*SW +: SW] = SW'(10);
    smp[1*SW +: SW] = SW'(20);
    smp[2*SW +: SW] = SW'(30);
    run_mix("three_voices", NV'(7), smp, 1'b0, 0);
    run_mix("all_max", '1, fill(255), 1'b0, 0);
    smp = '0;
    smp[0*SW +: SW] = SW'(128);
    smp[1*SW +: SW] = SW'(127);
    run_mix("sum_255", NV'(3), smp, 1'b0, 0);
    smp[1*SW +: SW] = SW'(128);
    run_mix("sum_256", NV'(3), smp, 1'b0, 0);
    run_mix("none_en", '0, fill(200), 1'b0, 0);
    smp = fill(0);
    smp[0*SW +: SW] = SW'(77);
    run_mix("one_voice", NV'(1), smp, 1'b0, 0);
    smp = fill(200);
    run_mix("three_200", NV'(7), smp, 1'b0, 0);
    chk("no_overrun_yet", 64'(bus.overrun), 64'(0));

    run_mix("scramble", NV'($urandom), rand_smp(), 1'b1, 5);
    chk("overrun_set", 64'(bus.overrun), 64'(1));
    for (int n = 0; n < 8; n++) begin
      run_mix("random", NV'($urandom), rand_smp(), n[0], 0);
      chk("overrun_sticky", 64'(bus.overrun), 64'(1));
    end

    // Reset during cycle 7 of a mix aborts it with no valid pulse.
    bus.voice_en      = '1;
    bus.voice_sample  = fill(100);
    bus.sample_strobe = 1'b1;
    @(negedge clk);
    bus.sample_strobe = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sample", 64'(bus.mixed_sample), 64'(0));
    chk("abort_valid", 64'(bus.mixed_valid), 64'(0));
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_overrun", 64'(bus.overrun), 64'(0));
    for (int k = 0; k < int'(NV) + 4; k++) begin
      @(negedge clk);
      chk("abort_no_valid", 64'(bus.mixed_valid), 64'(0));
    end
    smp = rand_smp();
    exp = ref_mix('1, smp);
    run_mix("after_rst", '1, smp, 1'b0, 0);
    chk("after_rst_model", 64'(bus.mixed_sample), 64'(exp));
    chk("after_rst_overrun", 64'(bus.overrun), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
